// File: rtl/time_keeper.sv
// time_keeper: BCD time-of-day core. An exact prescaler turns Clk_100M into
// one-second ticks; hours/minutes are kept as 24 h BCD, seconds in binary.
// Front-panel set edges, 12/24 h display mapping and a latched alarm.
module time_keeper #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int CNT_W         = 27
) (
  input  logic       Clk_100M,
  input  logic       Reset,
  input  logic       min_up,
  input  logic       hour_up,
  input  logic       mode_12h,
  input  logic       alarm_en,
  input  logic       alarm_ack,
  input  logic [3:0] alarm_h10,
  input  logic [3:0] alarm_h,
  input  logic [3:0] alarm_m10,
  input  logic [3:0] alarm_m,
  output logic [3:0] hours10,
  output logic [3:0] hours,
  output logic [3:0] minutes10,
  output logic [3:0] minutes,
  output logic       pm,
  output logic [5:0] seconds,
  output logic       sec_tick,
  output logic       alarm
);

  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] p_reg, p_next;
  logic [3:0]       h10_reg, h10_next, h_reg, h_next;
  logic [3:0]       m10_reg, m10_next, m_reg, m_next;
  logic [5:0]       s_reg, s_next;
  logic             prev_min_reg, prev_hour_reg;
  logic             sec_tick_reg, alarm_reg, alarm_next;
  logic             tick, min_edge, hour_edge, tick_eff, hour_inc, alarm_match;
  logic [4:0]       hour_bin, disp12;

  assign tick      = (p_reg == P_LAST);
  assign min_edge  = min_up & ~prev_min_reg;
  assign hour_edge = hour_up & ~prev_hour_reg;
  // A minute set discards any coincident tick.
  assign tick_eff  = tick & ~min_edge;

  // Next time-of-day: minute set or tick, then a single merged hour increment.
  always_comb begin
    p_next   = (tick | min_edge) ? '0 : p_reg + CNT_W'(1);
    s_next   = s_reg;
    m_next   = m_reg;
    m10_next = m10_reg;
    h_next   = h_reg;
    h10_next = h10_reg;
    hour_inc = hour_edge;
    if (min_edge) begin
      s_next = 6'd0;
      if (m_reg == 4'd9) begin
        m_next   = 4'd0;
        m10_next = (m10_reg == 4'd5) ? 4'd0 : m10_reg + 4'd1;
      end else begin
        m_next = m_reg + 4'd1;
      end
    end else if (tick) begin
      if (s_reg == 6'd59) begin
        s_next = 6'd0;
        if (m_reg == 4'd9) begin
          m_next = 4'd0;
          if (m10_reg == 4'd5) begin
            m10_next = 4'd0;
            hour_inc = 1'b1;
          end else begin
            m10_next = m10_reg + 4'd1;
          end
        end else begin
          m_next = m_reg + 4'd1;
        end
      end else begin
        s_next = s_reg + 6'd1;
      end
    end
    if (hour_inc) begin
      if (h10_reg == 4'd2 && h_reg == 4'd3) begin
        h10_next = 4'd0;
        h_next   = 4'd0;
      end else if (h_reg == 4'd9) begin
        h10_next = h10_reg + 4'd1;
        h_next   = 4'd0;
      end else begin
        h_next = h_reg + 4'd1;
      end
    end
  end

  // Alarm only fires on a purely tick-driven update landing on hh:mm:00;
  // invalid alarm BCD can never equal the always-valid internal digits.
  always_comb begin
    alarm_match = tick_eff & ~hour_edge & alarm_en &
                  (h10_next == alarm_h10) & (h_next == alarm_h) &
                  (m10_next == alarm_m10) & (m_next == alarm_m) &
                  (s_next == 6'd0);
    if (alarm_match)
      alarm_next = 1'b1;
    else if (alarm_ack | ~alarm_en)
      alarm_next = 1'b0;
    else
      alarm_next = alarm_reg;
  end

  // State registers; reset samples the buttons so a held button is not an edge.
  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      p_reg         <= '0;
      h10_reg       <= 4'd0;
      h_reg         <= 4'd0;
      m10_reg       <= 4'd0;
      m_reg         <= 4'd0;
      s_reg         <= 6'd0;
      sec_tick_reg  <= 1'b0;
      alarm_reg     <= 1'b0;
      prev_min_reg  <= min_up;
      prev_hour_reg <= hour_up;
    end else begin
      p_reg         <= p_next;
      h10_reg       <= h10_next;
      h_reg         <= h_next;
      m10_reg       <= m10_next;
      m_reg         <= m_next;
      s_reg         <= s_next;
      sec_tick_reg  <= tick_eff;
      alarm_reg     <= alarm_next;
      prev_min_reg  <= min_up;
      prev_hour_reg <= hour_up;
    end
  end

  assign hour_bin = ({1'b0, h10_reg} * 5'd10) + {1'b0, h_reg};

  // Display mapping: combinational so a mode change shows immediately.
  always_comb begin
    hours10 = h10_reg;
    hours   = h_reg;
    pm      = 1'b0;
    disp12  = hour_bin;
    if (mode_12h) begin
      pm = (hour_bin >= 5'd12);
      if (hour_bin == 5'd0)
        disp12 = 5'd12;
      else if (hour_bin > 5'd12)
        disp12 = hour_bin - 5'd12;
      if (disp12 >= 5'd10) begin
        hours10 = 4'd1;
        hours   = 4'(disp12 - 5'd10);
      end else begin
        hours10 = 4'd0;
        hours   = 4'(disp12);
      end
    end
  end

  assign minutes10 = m10_reg;
  assign minutes   = m_reg;
  assign seconds   = s_reg;
  assign sec_tick  = sec_tick_reg;
  assign alarm     = alarm_reg;

endmodule

// File: doc/time_keeper.md
# time_keeper

Parametrised BCD time-of-day core for the FPGA clock. It derives one-second ticks from Clk_100M through an exact prescaler and keeps hours, minutes and seconds internally in 24 h format. It applies minute/hour set pulses from the debounced front-panel buttons, selects 12 h or 24 h display format at runtime, and raises a latched alarm. It feeds the seven-segment driver digit inputs and the seconds LEDs.

## Interface
- TICKS_PER_SEC, 100_000_000: Clk_100M cycles per second tick; must be ≥ 2. The bench uses 4.
- CNT_W, 27: prescaler width; must satisfy 2^CNT_W ≥ TICKS_PER_SEC.
- Clk_100M  in  1  system clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- min_up  in  1  debounced level; each rising edge adds one minute.
- hour_up  in  1  debounced level; each rising edge adds one hour.
- mode_12h  in  1  1 = 12 h display format, 0 = 24 h display format.
- alarm_en  in  1  alarm enable.
- alarm_ack  in  1  clears a latched alarm.
- alarm_h10, alarm_h, alarm_m10, alarm_m  in  4 each  alarm time, 24 h BCD.
- hours10, hours, minutes10, minutes  out  4 each  displayed BCD digits.
- pm  out  1  high when mode_12h = 1 and internal hour ≥ 12.
- seconds  out  6  binary seconds, 0–59.
- sec_tick  out  1  one-cycle pulse per second.
- alarm  out  1  latched alarm flag.

## Operation
- **Internal state:** H10:H (00–23), M10:M (00–59), S (0–59 binary), prescaler P, and prev_min / prev_hour edge registers.
- **Reset:**
  - Time = 00:00:00, P = 0, sec_tick = 0, alarm = 0.
  - prev_min and prev_hour load the current min_up and hour_up, so a button held through reset does not increment.
- **Prescaler:**
  - P increments every cycle.
  - When P = TICKS_PER_SEC−1, P returns to 0 and a tick occurs.
- **Tick:**
  - S increments; 59 wraps to 0 with a carry into M.
  - M 9→0 carries into M10; M10 5→0 carries into the hour.
  - Hour 23→00 wraps, with no date carry.
- **Minute set** (min_up high and prev_min low):
  - M/M10 increment, 59→00 wraps, with no carry into hours.
  - S and P are cleared.
  - Any tick in the same cycle is discarded.
- **Hour set** (hour_up high and prev_hour low):
  - Hour increments, 23→00 wraps.
  - If a tick carries into the hour in the same cycle, the hour still advances by exactly one; the carries merge.
  - Seconds and minutes still follow the tick.
- **Both set edges in the same cycle:** both are applied. S = 0, P = 0, minute +1 and hour +1, each field wrapping independently.
- **Display mapping:**
  - mode_12h = 0: outputs equal the internal digits.
  - mode_12h = 1: hour 0 → 12, hours 1–12 unchanged, hours 13–23 → hour−12; hours10 is 0 or 1.
  - Display outputs are combinational from the state registers and mode_12h, so a mode change is visible in the same cycle.
- **Alarm:**
  - alarm sets on a tick-driven update whose new time equals alarm_h10:alarm_h:alarm_m10:alarm_m:00 while alarm_en = 1.
  - Set-driven updates never set it.
  - alarm clears on alarm_ack = 1 or alarm_en = 0.
  - If set and clear conditions occur in the same cycle, set wins only if alarm_en = 1.
- **Invalid alarm BCD** (for example 25 or 7A): never matches; no error reported.

## Timing
- sec_tick is registered: high for exactly one cycle, on the cycle after the edge at which P wraps.
- seconds changes on that same edge.
- First tick after reset: sec_tick is high in cycle TICKS_PER_SEC+1 after Reset deasserts. Thereafter the period is exactly TICKS_PER_SEC cycles.
- Set response: the time updates on the first edge that samples the button high.
  - One increment per rising edge, regardless of how long the button is held.
  - Rising edges can be as close as every 2 cycles.
- Alarm latency: alarm goes high on the same edge that loads the matching time.
- Reset asserted mid-operation takes priority over every other event on that edge.

## Test plan
- **Reset and prescaler:** Reset for 3 cycles, then run with TICKS_PER_SEC = 4 → 00:00:00 with all outputs 0; sec_tick every 4 cycles; seconds reaches 59 then 0 with minutes = 1.
- **Full-day wrap:** preload 23:59:59 via set edges and ticks, then one tick → 00:00:00; in 12 h mode this shows 12:00 with pm = 0.
- **Set buttons:**
  - 60 min_up edges from 00:59 → 00:59, hour unchanged, seconds = 0.
  - hour_up held high for 20 cycles → exactly +1 hour.
  - min_up high during Reset → no increment after release.
- **Simultaneous events:**
  - hour_up edge on the tick that carries 09:59:59 → 10:00:00.
  - min_up edge coincident with a tick → seconds = 0, minute +1 only.
- **12 h mapping:** sweep hours 0, 1, 11, 12, 13, 23 → display 12/1/11/12/1/11 with pm 0/0/0/1/1/1; mode_12h = 0 → 00/01/11/12/13/23 with pm = 0.
- **Alarm:**
  - Alarm 07:30, alarm_en = 1, tick into 07:30:00 → alarm = 1 on that edge.
  - alarm_ack pulse → alarm = 0.
  - Setting 07:30 via the buttons → alarm stays 0.
  - alarm_en = 0 → alarm cleared.
